load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The core-side ports SHALL be:
- core_read_enable  in  1  load request.
- core_write_enable  in  1  store request.
- core_address  in  32  byte address.
- core_write_data  in  32  store data in bits [n:0].
- core_format  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-003 The core-side outputs SHALL be:
- core_read_data  out  32  aligned, extended load result.
- core_stall  out  1  core holds PC/regfile while high.
- core_misaligned  out  1  one-cycle misaligned-access flag.
REQ-004 The bus-side ports SHALL be:
- bus_request  out  1  transaction valid.
- bus_write  out  1  1 = write.
- bus_address  out  32  word-aligned address, bits [1:0] = 00.
- bus_write_data  out  32  lane-positioned data.
- bus_byte_enable  out  4  active lanes.
- bus_ack  in  1  transaction complete.
- bus_read_data  in  32  read word, valid with bus_ack.

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, DONE, plus ACCESS2 only when MISALIGNED_SPLIT_EN is defined.
REQ-006 While IDLE with either enable high, the FSM SHALL go to ACCESS on the next edge; a misaligned access with splitting disabled SHALL go to DONE instead.
REQ-007 core_stall SHALL equal (core_read_enable | core_write_enable) & (state != DONE), combinationally.
REQ-008 The core SHALL hold all core_* inputs stable while core_stall is high; the block SHALL latch them on leaving IDLE.
REQ-009 bus_request SHALL be high in ACCESS and ACCESS2 only.
REQ-010 bus_address, bus_write, bus_write_data and bus_byte_enable SHALL stay constant until bus_ack; no timeout.
REQ-011 bus_ack SHALL be ignored while bus_request is low.
REQ-012 On bus_ack in ACCESS, the FSM SHALL go to DONE, or to ACCESS2 if a second word is needed.
REQ-013 On bus_ack in ACCESS2, the FSM SHALL go to DONE.
REQ-014 DONE SHALL last exactly one cycle, then return to IDLE; core_read_data SHALL be valid during DONE.
REQ-015 Minimum latency SHALL be 3 cycles (IDLE, ACCESS with ack, DONE): core_stall high for 2 cycles.
REQ-016 Byte enables SHALL be: B = 1 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111. Reserved formats SHALL be treated as W.
REQ-017 Write data SHALL be shifted left by 8*addr[1:0] within the word.
REQ-018 Read data SHALL be shifted right by 8*addr[1:0], then sign-extended (B, H) or zero-extended (BU, HU) to 32 bits.
REQ-019 Misaligned SHALL mean H/HU with addr[0]=1, or W with addr[1:0] != 00.
REQ-020 core_read_data SHALL be 0 outside DONE.

Reset
REQ-021 On reset, the FSM SHALL go to IDLE and all outputs SHALL be 0, including core_read_data and core_misaligned.
REQ-022 Reset mid-transaction SHALL drop bus_request at that edge and abandon the access; a later bus_ack SHALL be ignored.

Configuration
REQ-023 With MISALIGNED_SPLIT_EN defined:
- A misaligned access inside one word SHALL use one transaction with shifted lanes.
- A word-crossing access SHALL use ACCESS at addr & ~3, then ACCESS2 at (addr & ~3) + 4, wrapping 0xFFFFFFFC to 0x00000000, with byte enables and data split across the two words.
- core_misaligned SHALL stay 0.
REQ-024 Without MISALIGNED_SPLIT_EN, a misaligned access SHALL:
- go IDLE -> DONE;
- issue no bus transaction;
- set core_misaligned = 1 and core_read_data = 0 for that DONE cycle.

Verification
REQ-025 SW at 0x100, data 0xDEADBEEF, ack after 2 wait cycles -> one write to 0x100, enables 1111, core_stall high for 4 cycles.
REQ-026 LB at 0x203, bus word 0x80AABBCC -> enables 1000, core_read_data 0xFFFFFF80; LBU gives 0x00000080.
REQ-027 SH at 0x102, data 0x00001234 -> bus_write_data 0x12340000, enables 1100.
REQ-028 LW at 0x101 without the macro -> no bus_request, core_misaligned pulses 1 cycle, core_read_data 0.
REQ-029 LW at 0x103 with the macro, words 0x44332211 at 0x100 and 0x88776655 at 0x104 -> two transactions (enables 1000, then 0111), core_read_data 0x77665544.
REQ-030 Reset asserted in ACCESS before ack, then ack -> bus_request 0 after the reset edge, FSM IDLE, late ack ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: bridges a core load/store port to a single-word request/ack bus.
// Define MISALIGNED_SPLIT_EN to service misaligned accesses (two words when crossing).
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_read_enable,
  input  logic        core_write_enable,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [2:0]  core_format,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  output logic        core_misaligned,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  input  logic        bus_ack,
  input  logic [31:0] bus_read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
`ifdef MISALIGNED_SPLIT_EN
  localparam logic [1:0] ACCESS2 = 2'd3;
`endif

  // Byte lanes over two consecutive words; bits [7:4] belong to the following word.
  function automatic logic [7:0] fmt_lanes(input logic [1:0] off, input logic [2:0] fmt);
    logic [7:0] base;
    case (fmt)
      3'b000, 3'b100: base = 8'h01;
      3'b001, 3'b101: base = 8'h03;
      default:        base = 8'h0f;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] fmt);
    case (fmt)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      default:        return off != 2'b00;
    endcase
  endfunction

  // words = {upper word, lower word}; shift the addressed bytes down and extend.
  function automatic logic [31:0] load_extend(input logic [2:0] fmt, input logic [1:0] off,
                                              input logic [63:0] words);
    logic [31:0] s;
    s = 32'(words >> {off, 3'b000});
    case (fmt)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  fmt_q, fmt_d;
  logic        write_q, write_d;
  logic        bus_request_q, bus_request_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic [31:0] bus_write_data_q, bus_write_data_d;
  logic [3:0]  bus_byte_enable_q, bus_byte_enable_d;
  logic [31:0] core_read_data_q, core_read_data_d;
  logic        core_misaligned_q, core_misaligned_d;
`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] lo_word_q, lo_word_d;
  logic        cross_q, cross_d;
  logic [3:0]  hi_be_q, hi_be_d;
  logic [31:0] hi_data_q, hi_data_d;
`else
  logic        mis_in;
  logic        unused_hi;
`endif

  logic [7:0]  be8_in;
  logic [63:0] wd64_in;

  always_comb begin
    be8_in  = fmt_lanes(core_address[1:0], core_format);
    wd64_in = {32'h0, core_write_data} << {core_address[1:0], 3'b000};
  end

`ifndef MISALIGNED_SPLIT_EN
  // Upper-word lanes only matter when accesses may be split.
  assign unused_hi = ^{be8_in[7:4], wd64_in[63:32]};
  assign mis_in    = is_misaligned(core_address[1:0], core_format);
`endif

  always_comb begin
    state_d           = state_q;
    off_d             = off_q;
    fmt_d             = fmt_q;
    write_d           = write_q;
    bus_request_d     = bus_request_q;
    bus_write_d       = bus_write_q;
    bus_address_d     = bus_address_q;
    bus_write_data_d  = bus_write_data_q;
    bus_byte_enable_d = bus_byte_enable_q;
    core_read_data_d  = core_read_data_q;
    core_misaligned_d = core_misaligned_q;
`ifdef MISALIGNED_SPLIT_EN
    lo_word_d         = lo_word_q;
    cross_d           = cross_q;
    hi_be_d           = hi_be_q;
    hi_data_d         = hi_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (core_read_enable | core_write_enable) begin
          off_d             = core_address[1:0];
          fmt_d             = core_format;
          write_d           = core_write_enable;
          bus_write_d       = core_write_enable;
          bus_address_d     = {core_address[31:2], 2'b00};
          bus_byte_enable_d = be8_in[3:0];
          bus_write_data_d  = wd64_in[31:0];
`ifdef MISALIGNED_SPLIT_EN
          cross_d           = |be8_in[7:4];
          hi_be_d           = be8_in[7:4];
          hi_data_d         = wd64_in[63:32];
          state_d           = ACCESS;
          bus_request_d     = 1'b1;
`else
          if (mis_in) begin
            state_d           = DONE;
            core_misaligned_d = 1'b1;
            core_read_data_d  = 32'h0;
          end else begin
            state_d       = ACCESS;
            bus_request_d = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        if (bus_ack) begin
`ifdef MISALIGNED_SPLIT_EN
          if (cross_q) begin
            state_d           = ACCESS2;
            lo_word_d         = bus_read_data;
            bus_address_d     = bus_address_q + 32'd4;
            bus_byte_enable_d = hi_be_q;
            bus_write_data_d  = hi_data_q;
          end else begin
            state_d          = DONE;
            bus_request_d    = 1'b0;
            core_read_data_d = write_q ? 32'h0 : load_extend(fmt_q, off_q, {32'h0, bus_read_data});
          end
`else
          state_d          = DONE;
          bus_request_d    = 1'b0;
          core_read_data_d = write_q ? 32'h0 : load_extend(fmt_q, off_q, {32'h0, bus_read_data});
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ACCESS2: begin
        if (bus_ack) begin
          state_d          = DONE;
          bus_request_d    = 1'b0;
          core_read_data_d = write_q ? 32'h0 : load_extend(fmt_q, off_q, {bus_read_data, lo_word_q});
        end
      end
`endif
      DONE: begin
        state_d           = IDLE;
        core_read_data_d  = 32'h0;
        core_misaligned_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      off_q             <= 2'b00;
      fmt_q             <= 3'b000;
      write_q           <= 1'b0;
      bus_request_q     <= 1'b0;
      bus_write_q       <= 1'b0;
      bus_address_q     <= 32'h0;
      bus_write_data_q  <= 32'h0;
      bus_byte_enable_q <= 4'h0;
      core_read_data_q  <= 32'h0;
      core_misaligned_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      lo_word_q         <= 32'h0;
      cross_q           <= 1'b0;
      hi_be_q           <= 4'h0;
      hi_data_q         <= 32'h0;
`endif
    end else begin
      state_q           <= state_d;
      off_q             <= off_d;
      fmt_q             <= fmt_d;
      write_q           <= write_d;
      bus_request_q     <= bus_request_d;
      bus_write_q       <= bus_write_d;
      bus_address_q     <= bus_address_d;
      bus_write_data_q  <= bus_write_data_d;
      bus_byte_enable_q <= bus_byte_enable_d;
      core_read_data_q  <= core_read_data_d;
      core_misaligned_q <= core_misaligned_d;
`ifdef MISALIGNED_SPLIT_EN
      lo_word_q         <= lo_word_d;
      cross_q           <= cross_d;
      hi_be_q           <= hi_be_d;
      hi_data_q         <= hi_data_d;
`endif
    end
  end

  assign core_stall      = (core_read_enable | core_write_enable) & (state_q != DONE);
  assign core_read_data  = core_read_data_q;
  assign core_misaligned = core_misaligned_q;
  assign bus_request     = bus_request_q;
  assign bus_write       = bus_write_q;
  assign bus_address     = bus_address_q;
  assign bus_write_data  = bus_write_data_q;
  assign bus_byte_enable = bus_byte_enable_q;

endmodule
